// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit bimodal counter per entry.
// Lookup is combinational from registered state; updates and invalidates land on the clock edge.
module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_PC,
  output logic        is_branch_predict,
  output logic        BTB_hit,
  output logic [31:0] BTB_PC,
  input  logic        update_en,
  input  logic [31:0] update_PC,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        branch_miss_contral,
  input  logic        invalidate,
  output logic [31:0] update_count,
  output logic [31:0] miss_count
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [31:0]        update_count_q, update_count_d;
  logic [31:0]        miss_count_q, miss_count_d;

  logic [INDEX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0]   lk_tag, u_tag;
  logic               u_hit, u_accept, u_write;
  logic [1:0]         cnt_d;
  logic [31:0]        target_d;
  logic [3:0]         unused_pc_lsbs;

  assign unused_pc_lsbs = {lookup_PC[1:0], update_PC[1:0]};

  assign lk_idx = lookup_PC[INDEX_W+1:2];
  assign lk_tag = lookup_PC[31:INDEX_W+2];
  assign u_idx  = update_PC[INDEX_W+1:2];
  assign u_tag  = update_PC[31:INDEX_W+2];

  // Lookup never touches state, so an unknown fetch PC can only disturb the outputs.
  assign BTB_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign is_branch_predict = BTB_hit && cnt_q[lk_idx][1];
  assign BTB_PC            = BTB_hit ? target_q[lk_idx] : 32'd0;

  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_accept = update_en && !invalidate;
  assign u_write  = u_accept && (u_hit || update_taken);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    cnt_d    = cnt_q[u_idx];
    target_d = target_q[u_idx];
    if (u_hit) begin
      if (update_taken) begin
        cnt_d    = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
        target_d = update_target;
      end else begin
        cnt_d    = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
      end
    end else if (update_taken) begin
      cnt_d    = 2'b10;
      target_d = update_target;
    end
  end

  always_comb begin
    update_count_d = update_count_q;
    miss_count_d   = miss_count_q;
    if (u_accept && (update_count_q != 32'hFFFF_FFFF)) update_count_d = update_count_q + 32'd1;
    if (branch_miss_contral && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  // NOTE: the table arrays are reset because the predictor must come out of reset with a known
  // counter value; this keeps them in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      update_count_q <= '0;
      miss_count_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read above sees pre-edge values.
      update_count_q <= update_count_d;
      miss_count_q   <= miss_count_d;
      if (invalidate) begin
        valid_q <= '0;
      end else if (u_write) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= target_d;
        cnt_q[u_idx]    <= cnt_d;
      end
    end
  end

  assign update_count = update_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed test of btb_predictor: allocation, counter saturation, aliasing, read-old timing,
// invalidate priority, counters and asynchronous reset.
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_PC;
  logic        is_branch_predict;
  logic        BTB_hit;
  logic [31:0] BTB_PC;
  logic        update_en;
  logic [31:0] update_PC;
  logic        update_taken;
  logic [31:0] update_target;
  logic        branch_miss_contral;
  logic        invalidate;
  logic [31:0] update_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;

  btb_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .lookup_PC           (lookup_PC),
    .is_branch_predict   (is_branch_predict),
    .BTB_hit             (BTB_hit),
    .BTB_PC              (BTB_PC),
    .update_en           (update_en),
    .update_PC           (update_PC),
    .update_taken        (update_taken),
    .update_target       (update_target),
    .branch_miss_contral (branch_miss_contral),
    .invalidate          (invalidate),
    .update_count        (update_count),
    .miss_count          (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic pred, input logic [31:0] tgt);
    lookup_PC = pc;
    #1;
    check({tag, ".hit"},  {31'd0, BTB_hit}, {31'd0, hit});
    check({tag, ".pred"}, {31'd0, is_branch_predict}, {31'd0, pred});
    check({tag, ".pc"},   BTB_PC, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_en     = 1'b1;
    update_PC     = pc;
    update_taken  = taken;
    update_target = tgt;
    tick();
    update_en    = 1'b0;
    update_taken = 1'b0;
  endtask

  initial begin
    rst                 = 1'b0;
    lookup_PC           = 32'h0001_0000;
    update_en           = 1'b0;
    update_PC           = '0;
    update_taken        = 1'b0;
    update_target       = '0;
    branch_miss_contral = 1'b0;
    invalidate          = 1'b0;
    #2;
    look("rst", 32'h0001_0000, 1'b0, 1'b0, 32'h0);
    check("rst.ucnt", update_count, 32'd0);
    check("rst.mcnt", miss_count, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Allocate idx 4, tag 0x400: cnt starts weakly taken
    upd(32'h0001_0010, 1'b1, 32'h0001_0040);
    look("alloc", 32'h0001_0010, 1'b1, 1'b1, 32'h0001_0040);
    check("alloc.ucnt", update_count, 32'd1);

    // Counter walk: 2 ->1 ->0 ->0 (floor) ->1 ->2 ->3 ->3 (ceiling) ->2 ->1
    upd(32'h0001_0010, 1'b0, 32'h0);
    look("nt1", 32'h0001_0010, 1'b1, 1'b0, 32'h0001_0040);
    upd(32'h0001_0010, 1'b0, 32'h0);
    upd(32'h0001_0010, 1'b0, 32'h0);
    look("nt_floor", 32'h0001_0010, 1'b1, 1'b0, 32'h0001_0040);
    upd(32'h0001_0010, 1'b1, 32'h0001_0044);
    look("t_after_floor", 32'h0001_0010, 1'b1, 1'b0, 32'h0001_0044);
    upd(32'h0001_0010, 1'b1, 32'h0001_0044);
    upd(32'h0001_0010, 1'b1, 32'h0001_0044);
    upd(32'h0001_0010, 1'b1, 32'h0001_0044);
    look("t_sat", 32'h0001_0010, 1'b1, 1'b1, 32'h0001_0044);
    upd(32'h0001_0010, 1'b0, 32'h0);
    look("nt_from_sat", 32'h0001_0010, 1'b1, 1'b1, 32'h0001_0044);
    upd(32'h0001_0010, 1'b0, 32'h0);
    look("nt_second", 32'h0001_0010, 1'b1, 1'b0, 32'h0001_0044);
    check("walk.ucnt", update_count, 32'd10);

    // Alias at idx 4 with tag 0x401 replaces the entry, cnt back to weakly taken
    upd(32'h0001_0050, 1'b1, 32'h0001_0100);
    look("alias_old", 32'h0001_0010, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h0001_0050, 1'b1, 1'b1, 32'h0001_0100);

    // Not-taken on a missing tag or an empty slot must leave the table alone
    upd(32'h0001_0010, 1'b0, 32'h0);
    look("ntmiss_keep", 32'h0001_0050, 1'b1, 1'b1, 32'h0001_0100);
    look("ntmiss_old", 32'h0001_0010, 1'b0, 1'b0, 32'h0);
    upd(32'h0002_0000, 1'b0, 32'h0);
    look("ntmiss_empty", 32'h0002_0000, 1'b0, 1'b0, 32'h0);
    check("ntmiss.ucnt", update_count, 32'd13);

    // Same-cycle update and lookup: old contents now, new contents after the edge
    lookup_PC     = 32'h0001_0080;
    update_en     = 1'b1;
    update_PC     = 32'h0001_0080;
    update_taken  = 1'b1;
    update_target = 32'h0001_0200;
    look("same_pre_empty", 32'h0001_0080, 1'b0, 1'b0, 32'h0);
    tick();
    update_en = 1'b0;
    look("same_post_empty", 32'h0001_0080, 1'b1, 1'b1, 32'h0001_0200);
    update_en     = 1'b1;
    update_PC     = 32'h0001_0050;
    update_target = 32'h0001_0300;
    look("same_pre_hit", 32'h0001_0050, 1'b1, 1'b1, 32'h0001_0100);
    tick();
    update_en = 1'b0;
    look("same_post_hit", 32'h0001_0050, 1'b1, 1'b1, 32'h0001_0300);
    check("same.ucnt", update_count, 32'd15);

    // Invalidate wins over a simultaneous update and the update is not counted
    invalidate = 1'b1;
    upd(32'h0001_00C0, 1'b1, 32'h0001_0400);
    invalidate = 1'b0;
    look("inv_a", 32'h0001_0050, 1'b0, 1'b0, 32'h0);
    look("inv_b", 32'h0001_0080, 1'b0, 1'b0, 32'h0);
    look("inv_c", 32'h0001_00C0, 1'b0, 1'b0, 32'h0);
    check("inv.ucnt", update_count, 32'd15);

    // Mispredict pulses
    check("miss.pre", miss_count, 32'd0);
    branch_miss_contral = 1'b1;
    tick();
    tick();
    tick();
    branch_miss_contral = 1'b0;
    tick();
    check("miss.cnt", miss_count, 32'd3);

    // Asynchronous reset in the middle of a pending update
    upd(32'h0001_0010, 1'b1, 32'h0001_0500);
    look("pre_rst", 32'h0001_0010, 1'b1, 1'b1, 32'h0001_0500);
    check("pre_rst.ucnt", update_count, 32'd16);
    update_en     = 1'b1;
    update_PC     = 32'h0001_0090;
    update_taken  = 1'b1;
    update_target = 32'h0001_0600;
    #2;
    rst = 1'b0;
    look("async_rst", 32'h0001_0010, 1'b0, 1'b0, 32'h0);
    check("async_rst.ucnt", update_count, 32'd0);
    check("async_rst.mcnt", miss_count, 32'd0);
    tick();
    update_en    = 1'b0;
    update_taken = 1'b0;
    rst          = 1'b1;
    tick();
    look("post_rst_lost", 32'h0001_0090, 1'b0, 1'b0, 32'h0);
    check("post_rst.ucnt", update_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
